key_voice_scheduler: RTL and testbench
======================================

Name: key_voice_scheduler

Overview:
- Sits between the eight raw piano keys and the per-voice tone/ROM datapath.
- Debounces each key and allocates pressed keys to NUM_VOICES tone voices; steals a voice when all voices are busy.
- Outputs per-voice note index and enable, active-voice count, and a mix attenuation shift for the summing mixer.

Parameters:
- NUM_VOICES, 4, number of tone voices. Fixed at 4 in this revision.
- DEB_COUNT, 50000, cycles a synchronized key must hold a new level before it is accepted. Must be >= 16.
- DEB_W, 16, debounce counter width. Must satisfy 2^DEB_W > DEB_COUNT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- keys  in  8  raw key levels (bit i = key i, 1 = pressed); asynchronous to clk
- key_state  out  8  debounced key levels
- voice_on  out  4  voice v active
- voice_note  out  12  3-bit key index per voice; voice v at bits [3v+2:3v]
- active_cnt  out  3  number of set voice_on bits, 0..4
- mix_shift  out  2  mixer right-shift: 0 for cnt 0/1, 1 for cnt 2, 2 for cnt 3/4
- steal_pulse  out  1  one-cycle pulse when a voice is stolen

Behaviour:
- Reset (async, rst_n=0): all outputs 0, synchronizers 0, counters 0, pending bits 0, steal_ptr 0. Release from reset is sampled synchronously.
- Synchronizer: 2-flop per key produces ks[i].
- Debounce, per key:
  - If ks[i]==key_state[i], the counter clears.
  - Otherwise the counter increments. When it reaches DEB_COUNT-1 while still differing, key_state[i] toggles and the counter clears.
  - A glitch shorter than DEB_COUNT cycles never changes key_state.
  - A clean change appears on key_state DEB_COUNT+2 cycles after keys changes (±1 cycle).
- Event capture:
  - A 0->1 on key_state[i] sets press_pend[i] and clears rel_pend[i].
  - A 1->0 sets rel_pend[i] and clears press_pend[i].
- Scheduler: serves exactly one event per cycle with this priority:
  - Any rel_pend before any press_pend.
  - Lowest key index first within each class.
  - The served pending bit clears in the same cycle.
- Release of key k:
  - Clear voice_on[v] for every v with voice_on[v]=1 and note==k.
  - If no voice matches (key was stolen), no-op.
  - voice_note retains its old value.
- Press of key k:
  - If a voice is already on with note==k, no-op.
  - Else, if any voice is free, the lowest-index free voice v gets voice_on=1, note=k.
  - Else steal voice steal_ptr: note=k, voice_on stays 1, steal_pulse=1 for one cycle, steal_ptr increments modulo 4.
- steal_ptr changes only on a steal.
- Latency: voice outputs update on the clock edge after the scheduler serves an event, i.e. one cycle after key_state changes if nothing else is pending. With all 8 pending, the queue drains within 8 cycles.
- active_cnt and mix_shift are registered. They update in the same cycle as voice_on and are always consistent with it.
- Simultaneous key_state changes on several keys: all are captured and served in priority order across successive cycles.
- Since DEB_COUNT >= 16, a key cannot generate a second event before its first is served.
- Reset mid-operation clears all voices immediately. Keys still held after reset re-debounce and re-allocate normally.

Test Plan:
- Reset: rst_n=0 with keys=8'hFF -> all outputs 0. Release reset with DEB_COUNT=16 -> key_state=8'hFF ~18 cycles later; voices then hold notes 0,1,2,3 in voices 0..3; steal_pulse fires 4 times as keys 4..7 are served.
- Glitch: pulse keys[2] high for 10 cycles -> key_state, voice_on stay 0. Hold key 2 for 20 cycles -> key_state=8'h04, voice_on=4'b0001, note0=2, active_cnt=1, mix_shift=0.
- Allocation/release: press keys 1,5,6 in sequence -> voice_on=4'b0111, notes 1,5,6, mix_shift=2. Release key 5 -> voice_on=4'b0101, active_cnt=2, mix_shift=1. Press key 7 -> voice 1 gets note 7.
- Stealing: voices full with keys 0..3; press key 4 -> voice 0 note=4, steal_pulse=1 for one cycle, steal_ptr=1. Press key 5 -> voice 1 note=5. Release key 0 -> no voice change.
- Simultaneous: keys 8'h00->8'h81 in one cycle -> key 0 lands in voice 0 one cycle before key 7 lands in voice 1. Release both together -> both voices clear on successive cycles, active_cnt reaches 0.
- Async reset mid-operation: assert rst_n low between clock edges with 3 voices on -> outputs clear before the next clk edge.

Source files
------------

// File: rtl/key_voice_scheduler.sv
// Debounces eight piano keys and allocates them to tone voices, stealing round-robin when all voices are busy.
// Voice outputs follow one cycle after a debounced edge; there is no backpressure, and queued events drain at one per cycle.
module key_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int DEB_COUNT  = 50000,
   parameter int DEB_W      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                keys,
   output logic [7:0]                key_state,
   output logic [NUM_VOICES-1:0]     voice_on,
   output logic [3*NUM_VOICES-1:0]   voice_note,
   output logic [2:0]                active_cnt,
   output logic [1:0]                mix_shift,
   output logic                      steal_pulse
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

   logic [7:0]                    sync1_q, sync1_d;
   logic [7:0]                    sync2_q, sync2_d;
   logic [DEB_W-1:0]              deb_cnt_q [8];
   logic [DEB_W-1:0]              deb_cnt_d [8];
   logic [7:0]                    key_state_q, key_state_d;
   logic [7:0]                    press_pend_q, press_pend_d;
   logic [7:0]                    rel_pend_q, rel_pend_d;
   logic [NUM_VOICES-1:0]         voice_on_q, voice_on_d;
   logic [3*NUM_VOICES-1:0]       voice_note_q, voice_note_d;
   logic [2:0]                    active_cnt_q, active_cnt_d;
   logic [1:0]                    mix_shift_q, mix_shift_d;
   logic                          steal_pulse_q, steal_pulse_d;
   logic [1:0]                    steal_ptr_q, steal_ptr_d;

   logic [7:0] key_rise;
   logic [7:0] key_fall;
   logic [2:0] serve_key;
   logic       note_hit;
   logic       free_found;
   logic [1:0] free_v;

   function automatic logic [2:0] lowest_idx(input logic [7:0] vec);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   always_comb begin
      sync1_d     = keys;
      sync2_d     = sync1_q;
      key_state_d = key_state_q;
      for (int i = 0; i < 8; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != key_state_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               key_state_d[i] = ~key_state_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
      key_rise = key_state_d & ~key_state_q;
      key_fall = ~key_state_d & key_state_q;
   end

   always_comb begin
      press_pend_d  = press_pend_q;
      rel_pend_d    = rel_pend_q;
      voice_on_d    = voice_on_q;
      voice_note_d  = voice_note_q;
      steal_ptr_d   = steal_ptr_q;
      steal_pulse_d = 1'b0;
      serve_key     = '0;
      note_hit      = 1'b0;
      free_found    = 1'b0;
      free_v        = '0;

      // Releases outrank presses so a full voice bank frees up before a steal is considered.
      if (|rel_pend_q) begin
         serve_key             = lowest_idx(rel_pend_q);
         rel_pend_d[serve_key] = 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_on_q[v] && (voice_note_q[3*v +: 3] == serve_key)) voice_on_d[v] = 1'b0;
         end
      end else if (|press_pend_q) begin
         serve_key               = lowest_idx(press_pend_q);
         press_pend_d[serve_key] = 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_on_q[v] && (voice_note_q[3*v +: 3] == serve_key)) note_hit = 1'b1;
            if (!free_found && !voice_on_q[v]) begin
               free_found = 1'b1;
               free_v     = 2'(v);
            end
         end
         if (!note_hit) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (free_found && (2'(v) == free_v)) begin
                  voice_on_d[v]          = 1'b1;
                  voice_note_d[3*v +: 3] = serve_key;
               end else if (!free_found && (2'(v) == steal_ptr_q)) begin
                  voice_note_d[3*v +: 3] = serve_key;
               end
            end
            if (!free_found) begin
               steal_pulse_d = 1'b1;
               steal_ptr_d   = steal_ptr_q + 2'd1;
            end
         end
      end

      for (int i = 0; i < 8; i++) begin
         if (key_rise[i]) begin
            press_pend_d[i] = 1'b1;
            rel_pend_d[i]   = 1'b0;
         end
         if (key_fall[i]) begin
            rel_pend_d[i]   = 1'b1;
            press_pend_d[i] = 1'b0;
         end
      end

      active_cnt_d = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         active_cnt_d = active_cnt_d + 3'(voice_on_d[v]);
      end
      case (active_cnt_d)
         3'd0, 3'd1: mix_shift_d = 2'd0;
         3'd2:       mix_shift_d = 2'd1;
         default:    mix_shift_d = 2'd2;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         for (int i = 0; i < 8; i++) deb_cnt_q[i] <= '0;
         key_state_q   <= '0;
         press_pend_q  <= '0;
         rel_pend_q    <= '0;
         voice_on_q    <= '0;
         voice_note_q  <= '0;
         active_cnt_q  <= '0;
         mix_shift_q   <= '0;
         steal_pulse_q <= 1'b0;
         steal_ptr_q   <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         for (int i = 0; i < 8; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         key_state_q   <= key_state_d;
         press_pend_q  <= press_pend_d;
         rel_pend_q    <= rel_pend_d;
         voice_on_q    <= voice_on_d;
         voice_note_q  <= voice_note_d;
         active_cnt_q  <= active_cnt_d;
         mix_shift_q   <= mix_shift_d;
         steal_pulse_q <= steal_pulse_d;
         steal_ptr_q   <= steal_ptr_d;
      end
   end

   assign key_state   = key_state_q;
   assign voice_on    = voice_on_q;
   assign voice_note  = voice_note_q;
   assign active_cnt  = active_cnt_q;
   assign mix_shift   = mix_shift_q;
   assign steal_pulse = steal_pulse_q;

endmodule

// File: tb/tb_key_voice_scheduler.sv
// Directed bench for key_voice_scheduler with a short debounce window.
module tb_key_voice_scheduler;

   logic        clk;
   logic        rst_n;
   logic [7:0]  keys;
   logic [7:0]  key_state;
   logic [3:0]  voice_on;
   logic [11:0] voice_note;
   logic [2:0]  active_cnt;
   logic [1:0]  mix_shift;
   logic        steal_pulse;

   int total = 0;
   int bad   = 0;

   key_voice_scheduler #(
      .NUM_VOICES (4),
      .DEB_COUNT  (16),
      .DEB_W      (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .keys        (keys),
      .key_state   (key_state),
      .voice_on    (voice_on),
      .voice_note  (voice_note),
      .active_cnt  (active_cnt),
      .mix_shift   (mix_shift),
      .steal_pulse (steal_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ks(input logic [7:0] target, input string tag);
      int n;
      n = 0;
      while (key_state !== target && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(tag, key_state, target);
   endtask

   task automatic set_keys(input logic [7:0] v, input string tag);
      @(negedge clk);
      keys = v;
      wait_ks(v, tag);
   endtask

   initial begin
      int n;
      int pulses;
      rst_n = 1'b0;
      keys  = 8'hFF;
      repeat (3) @(negedge clk);

      // reset state with all keys held
      check("rst_key_state", key_state, 8'h00);
      check("rst_voice_on", voice_on, 4'h0);
      check("rst_voice_note", voice_note, 12'h000);
      check("rst_active_cnt", active_cnt, 3'd0);
      check("rst_mix_shift", mix_shift, 2'd0);
      check("rst_steal", steal_pulse, 1'b0);

      // release reset: keys debounce, voices fill then get stolen
      rst_n = 1'b1;
      n = 0;
      while (key_state !== 8'hFF && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("deb_latency_ok", 32'(n >= 17 && n <= 19), 32'd1);
      repeat (4) @(negedge clk);
      check("fill_voice_on", voice_on, 4'hF);
      check("fill_notes", voice_note, 12'h688);
      check("fill_active", active_cnt, 3'd4);
      check("fill_mix", mix_shift, 2'd2);
      check("fill_no_steal", steal_pulse, 1'b0);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (steal_pulse === 1'b1) pulses++;
      end
      check("steal_pulse_cnt", pulses, 4);
      check("stolen_notes", voice_note, 12'hFAC);

      // release all: stolen keys are no-ops, notes retained
      set_keys(8'h00, "relall_ks");
      repeat (8) @(negedge clk);
      check("relall_voice_on", voice_on, 4'h0);
      check("relall_active", active_cnt, 3'd0);
      check("relall_notes_kept", voice_note, 12'hFAC);

      // glitch on key 2 shorter than the debounce window
      @(negedge clk);
      keys = 8'h04;
      repeat (10) @(negedge clk);
      keys = 8'h00;
      repeat (30) @(negedge clk);
      check("glitch_ks", key_state, 8'h00);
      check("glitch_voice_on", voice_on, 4'h0);

      // clean press of key 2
      set_keys(8'h04, "k2_ks");
      @(negedge clk);
      check("k2_voice_on", voice_on, 4'h1);
      check("k2_notes", voice_note, 12'hFAA);
      check("k2_active", active_cnt, 3'd1);
      check("k2_mix", mix_shift, 2'd0);
      set_keys(8'h00, "k2rel_ks");
      @(negedge clk);
      check("k2rel_voice_on", voice_on, 4'h0);

      // allocation and release
      set_keys(8'h02, "p1_ks");
      @(negedge clk);
      check("p1_voice_on", voice_on, 4'h1);
      set_keys(8'h22, "p5_ks");
      @(negedge clk);
      check("p5_voice_on", voice_on, 4'h3);
      set_keys(8'h62, "p6_ks");
      @(negedge clk);
      check("p6_voice_on", voice_on, 4'h7);
      check("p6_notes", voice_note, 12'hFA9);
      check("p6_active", active_cnt, 3'd3);
      check("p6_mix", mix_shift, 2'd2);
      set_keys(8'h42, "r5_ks");
      @(negedge clk);
      check("r5_voice_on", voice_on, 4'h5);
      check("r5_active", active_cnt, 3'd2);
      check("r5_mix", mix_shift, 2'd1);
      set_keys(8'hC2, "p7_ks");
      @(negedge clk);
      check("p7_voice_on", voice_on, 4'h7);
      check("p7_notes", voice_note, 12'hFB9);

      // stealing with voices full of keys 0..3
      set_keys(8'h00, "clr_ks");
      repeat (8) @(negedge clk);
      check("clr_voice_on", voice_on, 4'h0);
      set_keys(8'h0F, "full_ks");
      repeat (4) @(negedge clk);
      check("full_voice_on", voice_on, 4'hF);
      check("full_notes", voice_note, 12'h688);
      set_keys(8'h1F, "s4_ks");
      @(negedge clk);
      check("s4_pulse", steal_pulse, 1'b1);
      check("s4_notes", voice_note, 12'h68C);
      check("s4_voice_on", voice_on, 4'hF);
      @(negedge clk);
      check("s4_pulse_end", steal_pulse, 1'b0);
      set_keys(8'h3F, "s5_ks");
      @(negedge clk);
      check("s5_pulse", steal_pulse, 1'b1);
      check("s5_notes", voice_note, 12'h6AC);
      set_keys(8'h3E, "r0_ks");
      repeat (2) @(negedge clk);
      check("r0_voice_on", voice_on, 4'hF);
      check("r0_notes", voice_note, 12'h6AC);
      check("r0_no_steal", steal_pulse, 1'b0);

      // simultaneous press and release of keys 0 and 7
      set_keys(8'h00, "clr2_ks");
      repeat (8) @(negedge clk);
      check("clr2_voice_on", voice_on, 4'h0);
      set_keys(8'h81, "sim_ks");
      @(negedge clk);
      check("sim_first_on", voice_on, 4'h1);
      check("sim_first_note", voice_note[2:0], 3'd0);
      @(negedge clk);
      check("sim_second_on", voice_on, 4'h3);
      check("sim_second_note", voice_note[5:3], 3'd7);
      set_keys(8'h00, "simrel_ks");
      @(negedge clk);
      check("simrel_first_on", voice_on, 4'h2);
      check("simrel_first_cnt", active_cnt, 3'd1);
      @(negedge clk);
      check("simrel_second_on", voice_on, 4'h0);
      check("simrel_second_cnt", active_cnt, 3'd0);

      // asynchronous reset between clock edges with three voices on
      set_keys(8'h07, "pre_rst_ks");
      repeat (3) @(negedge clk);
      check("pre_rst_voice_on", voice_on, 4'h7);
      check("pre_rst_active", active_cnt, 3'd3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_voice_on", voice_on, 4'h0);
      check("arst_active", active_cnt, 3'd0);
      check("arst_key_state", key_state, 8'h00);
      check("arst_notes", voice_note, 12'h000);
      check("arst_mix", mix_shift, 2'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_ks(8'h07, "post_rst_ks");
      repeat (3) @(negedge clk);
      check("post_rst_voice_on", voice_on, 4'h7);
      check("post_rst_notes", voice_note, 12'h088);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
